hazard_control_unit: RTL and testbench

// Consumes ID/EX and EX/MEM pipeline-register outputs and the IF/ID operand fields, and issues the pipeline's stall, bubble and flush commands.
// - Load-use hazard: holds PC and IF/ID, and injects a bubble into ID/EX.
// - Taken branch: flushes the wrong-path instructions for FLUSH_CYCLES cycles.
// - Holds the whole pipeline while data memory is not ready.
// - Keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/hazard_control_unit_if.sv | 71 +++++++
 rtl/sat_counter.sv | 33 +++
 rtl/hazard_control_unit.sv | 133 +++++++++++++
 tb/tb_hazard_control_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control unit.
// Provides the FSM state encoding, register-specifier width and r0 index.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2,
        MEM_WAIT   = 2'd3
    } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// master: pipeline side (drives hazard inputs, takes commands and counters).
// slave:  hazard control unit (takes hazard inputs, drives commands).
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic             id_ex_MemRead;
    logic [REG_W-1:0] id_ex_rt;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             id_uses_rt;
    logic             ex_mem_Branch;
    logic             ex_mem_zero;
    logic             mem_ready;
    logic             ex_mem_mem_access;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             hold_all;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_ex_MemRead,
        output id_ex_rt,
        output if_id_rs,
        output if_id_rt,
        output id_uses_rt,
        output ex_mem_Branch,
        output ex_mem_zero,
        output mem_ready,
        output ex_mem_mem_access,
        input  pc_write,
        input  if_id_write,
        input  id_ex_bubble,
        input  flush_if_id,
        input  flush_id_ex,
        input  hold_all,
        input  state_o,
        input  stall_count,
        input  flush_count
    );

    modport slave (
        input  id_ex_MemRead,
        input  id_ex_rt,
        input  if_id_rs,
        input  if_id_rt,
        input  id_uses_rt,
        input  ex_mem_Branch,
        input  ex_mem_zero,
        input  mem_ready,
        input  ex_mem_mem_access,
        output pc_write,
        output if_id_write,
        output id_ex_bubble,
        output flush_if_id,
        output flush_id_ex,
        output hold_all,
        output state_o,
        output stall_count,
        output flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Ports: clock (updates on negedge), reset_n (async, active-low),
// en_i (count this cycle), count_o (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Issues stall, bubble, flush and memory-hold commands for a 5-stage pipe.
// Ports: clock (state updates on negedge), reset_n (async, active-low),
// bus (slave side: hazard inputs in, commands/state/counters out).
module hazard_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    hazard_control_unit_if.slave  bus
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);

    hcu_state_e state_q;
    hcu_state_e state_d;
    logic [1:0] fcnt_q;
    logic [1:0] fcnt_d;

    logic br;
    logic mw;
    logic lu;
    logic in_flush;
    logic mw_now;
    logic lu_now;
    logic br_take;
    logic flush;
    logic stall;
    logic flush_inc;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign br = bus.ex_mem_Branch & bus.ex_mem_zero;
    assign mw = bus.ex_mem_mem_access & ~bus.mem_ready;
    assign lu = bus.id_ex_MemRead
              & (bus.id_ex_rt != ZERO_REG)
              & ((bus.id_ex_rt == bus.if_id_rs)
                | (bus.id_uses_rt
                  & (bus.id_ex_rt == bus.if_id_rt)));

    assign in_flush = (state_q == BR_FLUSH);

    // A memory wait only bites once the flush window has drained; the
    // wrong-path instructions are being squashed anyway.
    assign mw_now = mw & ~in_flush;

    // The load has moved on after one stall cycle, so LOAD_STALL never
    // re-arms; inside a flush the ID instruction is discarded.
    assign lu_now = lu & ~in_flush & (state_q != LOAD_STALL);

    // A branch sitting in a frozen EX/MEM waits for memory, then acts.
    assign br_take = br & ~mw_now;
    assign flush   = (br | in_flush) & ~mw_now;

    // Flush beats stall so the branch target still loads into the PC.
    assign stall = (lu_now | mw_now) & ~flush;

    assign flush_inc = br_take & ~in_flush;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            BR_FLUSH: begin
                if (br) begin
                    state_d = BR_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end else if (fcnt_q <= 2'd1) begin
                    fcnt_d  = '0;
                    state_d = mw ? MEM_WAIT : RUN;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            default: begin
                if (br_take) begin
                    state_d = HAS_FLUSH ? BR_FLUSH : RUN;
                    fcnt_d  = FLUSH_LOAD;
                end else if (mw) begin
                    state_d = MEM_WAIT;
                end else if (lu_now) begin
                    state_d = LOAD_STALL;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (stall),
        .count_o (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (flush_inc),
        .count_o (flush_cnt)
    );

    // Enables read 1 in reset, every other command reads 0.
    assign bus.pc_write     = ~reset_n | ~stall;
    assign bus.if_id_write  = ~reset_n | ~stall;
    assign bus.id_ex_bubble = reset_n & lu_now & ~br;
    assign bus.flush_if_id  = reset_n & flush;
    assign bus.flush_id_ex  = reset_n & flush;
    assign bus.hold_all     = reset_n & mw_now;
    assign bus.state_o      = state_q;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_control_unit;
    import pipe_ctrl_pkg::*;

    localparam int FC   = 2;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clock;
    logic reset_n;

    hazard_control_unit_if #(.CNT_W(CW)) bus ();
    hazard_control_unit_if #(.CNT_W(4))  bus4 ();

    hazard_control_unit #(
        .CNT_W        (CW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    hazard_control_unit #(
        .CNT_W        (4),
        .FLUSH_CYCLES (FC)
    ) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total;
    int bad;

    // Model: remaining flush cycles, whether last cycle was a load-use
    // stall, whether last cycle ended waiting on memory, counter values.
    int m_left;
    bit m_stalled;
    bit m_held;
    int m_stall;
    int m_flush;

    bit e_pcw, e_bub, e_fl, e_hold;
    bit e_take, e_inf, e_mw, e_lun;

    task automatic model_reset();
        m_left    = 0;
        m_stalled = 0;
        m_held    = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic model_eval();
        bit br, mw, lu, mwn;
        br = bus.ex_mem_Branch && bus.ex_mem_zero;
        mw = bus.ex_mem_mem_access && !bus.mem_ready;
        lu = bus.id_ex_MemRead && (bus.id_ex_rt != '0)
          && ((bus.id_ex_rt == bus.if_id_rs)
            || (bus.id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
        e_inf  = (m_left > 0);
        mwn    = mw && !e_inf;
        e_lun  = lu && !e_inf && !m_stalled;
        e_fl   = (br || e_inf) && !mwn;
        e_pcw  = e_fl || !(e_lun || mwn);
        e_bub  = e_lun && !br;
        e_hold = mwn;
        e_take = br && !mwn;
        e_mw   = mw;
    endtask

    task automatic model_commit();
        if (!e_pcw && m_stall < CMAX) m_stall++;
        if (e_take) begin
            if (!e_inf && m_flush < CMAX) m_flush++;
            m_left = FC - 1;
        end else if (m_left > 0) begin
            m_left--;
        end
        m_stalled = e_lun && !e_take && !e_mw;
        m_held    = e_mw && !e_take && (m_left == 0);
    endtask

    function automatic logic [1:0] m_state();
        if (m_left > 0) return 2'd2;
        if (m_held)     return 2'd3;
        if (m_stalled)  return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [5:0] outs();
        return {bus.pc_write, bus.if_id_write, bus.id_ex_bubble,
                bus.flush_if_id, bus.flush_id_ex, bus.hold_all};
    endfunction

    function automatic logic [33:0] regs();
        return {bus.state_o, bus.stall_count, bus.flush_count};
    endfunction

    // Inputs change just after the negedge; outputs sampled 3 ns later.
    task automatic drive(input bit mr, input int ert, input int rs,
                         input int rt, input bit urt, input bit b,
                         input bit z, input bit acc, input bit rdy);
        bus.id_ex_MemRead     = mr;
        bus.id_ex_rt          = REG_W'(ert);
        bus.if_id_rs          = REG_W'(rs);
        bus.if_id_rt          = REG_W'(rt);
        bus.id_uses_rt        = urt;
        bus.ex_mem_Branch     = b;
        bus.ex_mem_zero       = z;
        bus.ex_mem_mem_access = acc;
        bus.mem_ready         = rdy;
        #3;
        model_eval();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic advance();
        @(negedge clock);
        #1;
        model_commit();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 5, 5, 0, 0, 1, 1, 1, 0);
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=110000", outs());
        end
        @(negedge clock);
        #1;
        total++;
        if (regs() !== 34'h0) begin
            bad++;
            $display("FAIL reset_regs got=%0h want=0", regs());
        end
        idle();
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_use();
        drive(1, 5, 5, 0, 0, 0, 0, 0, 1);
        total++;
        if (outs() !== 6'b001000) begin
            bad++;
            $display("FAIL lu_outs got=%b want=001000", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd1, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL lu_regs got=%0h want=%0h",
                     regs(), {2'd1, 16'd1, 16'd0});
        end
        drive(1, 5, 5, 0, 0, 0, 0, 0, 1);
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL lu_rearm got=%b want=110000", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd0, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL lu_after got=%0h want=%0h",
                     regs(), {2'd0, 16'd1, 16'd0});
        end
    endtask

    task automatic test_r0_load();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 1);
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL r0_outs got=%b want=110000", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd0, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL r0_regs got=%0h want=%0h",
                     regs(), {2'd0, 16'd1, 16'd0});
        end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1);
        total++;
        if (outs() !== 6'b110110) begin
            bad++;
            $display("FAIL br_outs got=%b want=110110", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd2, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL br_regs got=%0h want=%0h",
                     regs(), {2'd2, 16'd1, 16'd1});
        end
        idle();
        total++;
        if (outs() !== 6'b110110) begin
            bad++;
            $display("FAIL br_flush2 got=%b want=110110", outs());
        end
        advance();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL br_nottaken got=%b want=110000", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd0, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL br_end got=%0h want=%0h",
                     regs(), {2'd0, 16'd1, 16'd1});
        end
    endtask

    task automatic test_lu_br();
        drive(1, 5, 5, 0, 0, 1, 1, 0, 1);
        total++;
        if (outs() !== 6'b110110) begin
            bad++;
            $display("FAIL lubr_outs got=%b want=110110", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd2, 16'd1, 16'd2}) begin
            bad++;
            $display("FAIL lubr_regs got=%0h want=%0h",
                     regs(), {2'd2, 16'd1, 16'd2});
        end
        idle();
        advance();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            total++;
            if (outs() !== 6'b000001) begin
                bad++;
                $display("FAIL mw_outs i=%0d got=%b want=000001",
                         i, outs());
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL mw_ready got=%b want=110000", outs());
        end
        advance();
        total++;
        if (regs() !== {2'd0, 16'd4, 16'd2}) begin
            bad++;
            $display("FAIL mw_regs got=%0h want=%0h",
                     regs(), {2'd0, 16'd4, 16'd2});
        end
    endtask

    task automatic test_random();
        logic [5:0]  want_o;
        logic [33:0] want_r;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1,
                  $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) != 0);
            want_o = {e_pcw, e_pcw, e_bub, e_fl, e_fl, e_hold};
            total++;
            if (outs() !== want_o) begin
                bad++;
                $display("FAIL rand_outs cyc=%0d got=%b want=%b",
                         i, outs(), want_o);
            end
            advance();
            want_r = {m_state(), CW'(m_stall), CW'(m_flush)};
            total++;
            if (regs() !== want_r) begin
                bad++;
                $display("FAIL rand_regs cyc=%0d got=%0h want=%0h",
                         i, regs(), want_r);
            end
        end
    endtask

    task automatic test_saturate();
        bus4.ex_mem_mem_access = 1'b1;
        bus4.mem_ready         = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle();
            advance();
        end
        #1;
        total++;
        if ({bus4.pc_write, bus4.hold_all, bus4.stall_count}
            !== {2'b01, 4'hF}) begin
            bad++;
            $display("FAIL sat_stall got=%b%b %0h want=01 f",
                     bus4.pc_write, bus4.hold_all, bus4.stall_count);
        end
        bus4.mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus4.ex_mem_Branch = 1'b1;
            bus4.ex_mem_zero   = 1'b1;
            idle();
            advance();
            bus4.ex_mem_Branch = 1'b0;
            idle();
            advance();
        end
        total++;
        if ({bus4.stall_count, bus4.flush_count} !== 8'hFF) begin
            bad++;
            $display("FAIL sat_flush got=%0h want=ff",
                     {bus4.stall_count, bus4.flush_count});
        end
    endtask

    task automatic test_reset_mid_flush();
        idle();
        advance();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1);
        advance();
        idle();
        total++;
        if ({bus.state_o, outs()} !== {2'd2, 6'b110110}) begin
            bad++;
            $display("FAIL rst_pre got=%0h want=%0h",
                     {bus.state_o, outs()}, {2'd2, 6'b110110});
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({outs(), regs()} !== {6'b110000, 34'h0}) begin
            bad++;
            $display("FAIL rst_mid got=%0h want=%0h",
                     {outs(), regs()}, {6'b110000, 34'h0});
        end
        total++;
        if ({bus4.stall_count, bus4.flush_count} !== 8'h00) begin
            bad++;
            $display("FAIL rst_small got=%0h want=0",
                     {bus4.stall_count, bus4.flush_count});
        end
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle();
        total++;
        if (outs() !== 6'b110000) begin
            bad++;
            $display("FAIL rst_noflush got=%b want=110000", outs());
        end
        advance();
        total++;
        if (regs() !== 34'h0) begin
            bad++;
            $display("FAIL rst_post got=%0h want=0", regs());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        bus4.id_ex_MemRead     = 1'b0;
        bus4.id_ex_rt          = '0;
        bus4.if_id_rs          = '0;
        bus4.if_id_rt          = '0;
        bus4.id_uses_rt        = 1'b0;
        bus4.ex_mem_Branch     = 1'b0;
        bus4.ex_mem_zero       = 1'b0;
        bus4.ex_mem_mem_access = 1'b0;
        bus4.mem_ready         = 1'b1;
        model_reset();
        test_reset();
        test_load_use();
        test_r0_load();
        test_branch();
        test_lu_br();
        test_mem_wait();
        test_random();
        test_saturate();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
